udp_header_rx: RTL and testbench
================================

UDP_HEADER_RX -- requirements
Module: udp_header_rx

Interface
REQ-001 Parameter UDP_D_PORT_DEF, default 16'h04_D2, reset value of the local destination port register.
REQ-002 Parameter UDP_MAX_LEN, default 16'h05_C8 (1480), largest UDP Length field accepted.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  one clock; reset is synchronous and active-high.
REQ-005 data_in  input  8  received frame byte stream, shared with the IP header parser.
REQ-006 data_valid  input  1  high for every byte of a frame; low between frames.
REQ-007 ip_header_done  input  1  one-cycle pulse from the IP parser, coincident with the first UDP header byte on data_in.
REQ-008 udp_d_port  input  16  local destination port to match.
REQ-009 udp_s_port  output  16  captured source port, held until next accepted header.
REQ-010 udp_len  output  16  captured UDP Length field, held until next accepted header.
REQ-011 payload_data  output  8  payload byte, registered.
REQ-012 payload_valid  output  1  payload_data qualifier.
REQ-013 payload_last  output  1  marks final payload byte.
REQ-014 udp_done  output  1  one-cycle pulse, coincident with payload_last.
REQ-015 udp_err  output  1  one-cycle pulse on bad length or truncated payload.

Function
REQ-016 The FSM SHALL have states IDLE, SRC_PORT, DST_PORT, LENGTH, CHECKSUM, PAYLOAD, DROP.
REQ-017 IDLE: on ip_header_done && data_valid, the block SHALL capture data_in as src port MSB and go to SRC_PORT; otherwise stay.
REQ-018 SRC_PORT: the block SHALL capture the src port LSB and go to DST_PORT.
REQ-019 DST_PORT: the block SHALL take 2 bytes MSB first; after the 2nd byte it goes to LENGTH if {MSB,LSB}==udp_d_port, else to DROP with no udp_err.
REQ-020 LENGTH: the block SHALL take 2 bytes MSB first; after the 2nd byte, if 9 <= length <= UDP_MAX_LEN, it goes to CHECKSUM, else to DROP with a udp_err pulse on the following cycle.
REQ-021 udp_s_port and udp_len SHALL update only when LENGTH passes its check; on failure both keep their prior values.
REQ-022 CHECKSUM: the block SHALL skip 2 bytes without verifying them, then go to PAYLOAD.
REQ-023 PAYLOAD: each byte SHALL appear on payload_data with payload_valid high exactly one cycle after it is on data_in.
REQ-024 The internal payload counter SHALL be 16 bits, clear on entry to PAYLOAD, and never wrap within a legal length.
REQ-025 The (udp_len-8)th payload byte SHALL assert payload_last and udp_done with its payload_valid; the FSM then goes to DROP.
REQ-026 DROP: the block SHALL ignore bytes, including Ethernet padding and FCS, until data_valid is low, then go to IDLE.
REQ-027 data_valid low in any non-IDLE state SHALL force IDLE on the next edge.
REQ-028 data_valid low in PAYLOAD before payload_last SHALL pulse udp_err once, with no payload_valid or payload_last, one cycle later.
REQ-029 data_valid low in SRC_PORT/DST_PORT/LENGTH/CHECKSUM SHALL abort to IDLE with no udp_err.
REQ-030 ip_header_done outside IDLE SHALL be ignored.
REQ-031 payload_valid, payload_last, udp_done and udp_err SHALL be low in every cycle not specified above.

Reset
REQ-032 areset high SHALL on the next edge set state IDLE, counters 0, payload_valid, payload_last, udp_done and udp_err to 0, udp_s_port and udp_len to 0, and payload_data to 0.
REQ-033 Reset SHALL take precedence over all inputs, including mid-payload; no udp_err is produced for a frame aborted by reset.

Verification
REQ-034 Good frame: udp_d_port=16'h04D2, header 30 39 04 D2 00 0C 00 00, payload AA BB CC DD -> 4 payload_valid beats AA..DD, each 1 cycle after input, last on DD with udp_done; udp_s_port=16'h3039, udp_len=12.
REQ-035 Port mismatch: dst bytes 04 D3 -> no payload_valid, no udp_err, udp_s_port/udp_len unchanged, IDLE after data_valid drops.
REQ-036 Bad length: 00 05, then separately 05 C9 -> one udp_err pulse each, no payload.
REQ-037 Truncation: length 16'h0010, data_valid dropped after 3 payload bytes -> 3 beats, no payload_last, one udp_err pulse.
REQ-038 Padding: length 9, 1 payload byte, then 20 padding bytes -> 1 beat with payload_last, padding never output.
REQ-039 Reset mid-payload: areset after 2 payload bytes -> all outputs 0 next cycle, no udp_err; next good frame is received correctly.

Source files
------------

// File: rtl/udp_header_rx.sv
// ---------------------------------------------------------------------------
// udp_header_rx
// Parses the 8-byte UDP header that follows the IP header on a shared byte
// stream, filters on the local destination port, validates the Length field
// and forwards the payload bytes one cycle after they appear on data_in.
//
// Ports
//   aclk           in   1  clock, rising edge
//   areset         in   1  synchronous active-high reset
//   data_in        in   8  received frame byte
//   data_valid     in   1  high for every byte of a frame
//   ip_header_done in   1  pulse coincident with the first UDP header byte
//   udp_d_port     in  16  local destination port to match
//   udp_s_port     out 16  source port of the last accepted header
//   udp_len        out 16  Length field of the last accepted header
//   payload_data   out  8  payload byte (registered)
//   payload_valid  out  1  payload_data qualifier
//   payload_last   out  1  final payload byte marker
//   udp_done       out  1  pulse with payload_last
//   udp_err        out  1  pulse on bad length or truncated payload
// ---------------------------------------------------------------------------
module udp_header_rx #(
   parameter logic [15:0] UDP_D_PORT_DEF = 16'h04D2,
   parameter logic [15:0] UDP_MAX_LEN    = 16'h05C8
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   input  logic        ip_header_done,
   input  logic [15:0] udp_d_port,
   output logic [15:0] udp_s_port,
   output logic [15:0] udp_len,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last,
   output logic        udp_done,
   output logic        udp_err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SRC_PORT = 3'd1,
      DST_PORT = 3'd2,
      LENGTH   = 3'd3,
      CHECKSUM = 3'd4,
      PAYLOAD  = 3'd5,
      DROP     = 3'd6
   } state_t;

   state_t      r_state;
   logic        r_byte_sel;      // 0: first (MSB) byte of a 2-byte field
   logic [15:0] r_src_port;      // staged until the length check passes
   logic [7:0]  r_field_msb;
   logic [15:0] r_pay_cnt;
   logic [15:0] r_local_port;
   logic [15:0] r_udp_s_port;
   logic [15:0] r_udp_len;
   logic [7:0]  r_payload_data;
   logic        r_payload_valid;
   logic        r_payload_last;
   logic        r_udp_done;
   logic        r_udp_err;

   state_t      w_state_nxt;
   logic        w_byte_sel_nxt;
   logic        w_cap_src_msb;
   logic        w_cap_src_lsb;
   logic        w_cap_msb;
   logic        w_accept;
   logic        w_pay_clr;
   logic        w_beat;
   logic        w_last;
   logic        w_err_nxt;
   logic [15:0] w_field;
   logic        w_len_ok;
   logic [15:0] w_pay_cnt_inc;
   logic [15:0] w_pay_target;

   assign w_field       = {r_field_msb, data_in};
   assign w_len_ok      = (w_field >= 16'd9) && (w_field <= UDP_MAX_LEN);
   assign w_pay_cnt_inc = r_pay_cnt + 16'd1;
   // Payload byte count is Length minus the 8 header bytes; udp_len is
   // already the accepted length of the current frame while in PAYLOAD.
   assign w_pay_target  = r_udp_len - 16'd8;

   // Next-state and per-byte strobe decode.
   always_comb begin
      w_state_nxt    = r_state;
      w_byte_sel_nxt = r_byte_sel;
      w_cap_src_msb  = 1'b0;
      w_cap_src_lsb  = 1'b0;
      w_cap_msb      = 1'b0;
      w_accept       = 1'b0;
      w_pay_clr      = 1'b0;
      w_beat         = 1'b0;
      w_last         = 1'b0;
      w_err_nxt      = 1'b0;
      case (r_state)
         IDLE: begin
            w_byte_sel_nxt = 1'b0;
            if (ip_header_done && data_valid) begin
               w_cap_src_msb = 1'b1;
               w_state_nxt   = SRC_PORT;
            end else begin
               w_state_nxt   = IDLE;
            end
         end
         SRC_PORT: begin
            if (!data_valid) begin
               w_state_nxt = IDLE;
            end else begin
               w_cap_src_lsb  = 1'b1;
               w_byte_sel_nxt = 1'b0;
               w_state_nxt    = DST_PORT;
            end
         end
         DST_PORT: begin
            if (!data_valid) begin
               w_state_nxt = IDLE;
            end else if (!r_byte_sel) begin
               w_cap_msb      = 1'b1;
               w_byte_sel_nxt = 1'b1;
            end else begin
               w_byte_sel_nxt = 1'b0;
               // A port mismatch is not an error: the frame is simply not ours.
               if (w_field == r_local_port) begin
                  w_state_nxt = LENGTH;
               end else begin
                  w_state_nxt = DROP;
               end
            end
         end
         LENGTH: begin
            if (!data_valid) begin
               w_state_nxt = IDLE;
            end else if (!r_byte_sel) begin
               w_cap_msb      = 1'b1;
               w_byte_sel_nxt = 1'b1;
            end else begin
               w_byte_sel_nxt = 1'b0;
               if (w_len_ok) begin
                  w_accept    = 1'b1;
                  w_state_nxt = CHECKSUM;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = DROP;
               end
            end
         end
         CHECKSUM: begin
            if (!data_valid) begin
               w_state_nxt = IDLE;
            end else if (!r_byte_sel) begin
               w_byte_sel_nxt = 1'b1;
            end else begin
               w_byte_sel_nxt = 1'b0;
               w_pay_clr      = 1'b1;
               w_state_nxt    = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (!data_valid) begin
               // Frame ended before the declared length was delivered.
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_beat = 1'b1;
               if (w_pay_cnt_inc == w_pay_target) begin
                  w_last      = 1'b1;
                  w_state_nxt = DROP;
               end else begin
                  w_state_nxt = PAYLOAD;
               end
            end
         end
         DROP: begin
            // Swallow padding/FCS until the frame ends.
            if (!data_valid) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DROP;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_byte_sel_nxt = 1'b0;
         end
      endcase
   end

   // State, capture registers and registered outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state         <= IDLE;
         r_byte_sel      <= 1'b0;
         r_src_port      <= 16'h0000;
         r_field_msb     <= 8'h00;
         r_pay_cnt       <= 16'h0000;
         r_local_port    <= UDP_D_PORT_DEF;
         r_udp_s_port    <= 16'h0000;
         r_udp_len       <= 16'h0000;
         r_payload_data  <= 8'h00;
         r_payload_valid <= 1'b0;
         r_payload_last  <= 1'b0;
         r_udp_done      <= 1'b0;
         r_udp_err       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte_sel   <= w_byte_sel_nxt;
         r_local_port <= udp_d_port;
         if (w_cap_src_msb) begin
            r_src_port[15:8] <= data_in;
         end
         if (w_cap_src_lsb) begin
            r_src_port[7:0] <= data_in;
         end
         if (w_cap_msb) begin
            r_field_msb <= data_in;
         end
         if (w_accept) begin
            r_udp_s_port <= r_src_port;
            r_udp_len    <= w_field;
         end
         if (w_pay_clr) begin
            r_pay_cnt <= 16'h0000;
         end else if (w_beat) begin
            r_pay_cnt <= w_pay_cnt_inc;
         end
         if (w_beat) begin
            r_payload_data <= data_in;
         end
         r_payload_valid <= w_beat;
         r_payload_last  <= w_last;
         r_udp_done      <= w_last;
         r_udp_err       <= w_err_nxt;
      end
   end

   assign udp_s_port    = r_udp_s_port;
   assign udp_len       = r_udp_len;
   assign payload_data  = r_payload_data;
   assign payload_valid = r_payload_valid;
   assign payload_last  = r_payload_last;
   assign udp_done      = r_udp_done;
   assign udp_err       = r_udp_err;

endmodule

// File: tb/tb_udp_header_rx.sv
// ---------------------------------------------------------------------------
// tb_udp_header_rx
// Directed frames; the driver pushes expected payload beats / error pulses
// (with the cycle they must appear in) into a queue, and a monitor on the
// falling edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_udp_header_rx;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        data_valid = 1'b0;
   logic        ip_header_done = 1'b0;
   logic [15:0] udp_d_port = 16'h04D2;
   logic [15:0] udp_s_port;
   logic [15:0] udp_len;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic        payload_last;
   logic        udp_done;
   logic        udp_err;

   udp_header_rx dut (
      .aclk           (aclk),
      .areset         (areset),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .ip_header_done (ip_header_done),
      .udp_d_port     (udp_d_port),
      .udp_s_port     (udp_s_port),
      .udp_len        (udp_len),
      .payload_data   (payload_data),
      .payload_valid  (payload_valid),
      .payload_last   (payload_last),
      .udp_done       (udp_done),
      .udp_err        (udp_err)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      bit         last;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   // Monitor: every output event must match the head of the expected queue.
   always @(negedge aclk) begin
      ev_t e;
      checks++;
      if (!payload_valid && (payload_last || udp_done)) begin
         errors++;
         $display("FAIL stray_last: last=%0b done=%0b without valid, want 0 0 (cyc %0d)",
                  payload_last, udp_done, cyc);
      end
      if (payload_valid === 1'b1 || udp_err === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: valid=%0b err=%0b data=%h cyc=%0d, want no output",
                     payload_valid, udp_err, payload_data, cyc);
         end else begin
            e = exp_q.pop_front();
            if ((udp_err !== e.is_err) || (payload_valid !== !e.is_err) || (cyc != e.cyc) ||
                (!e.is_err && ((payload_data !== e.data) || (payload_last !== e.last) ||
                               (udp_done !== e.last)))) begin
               errors++;
               $display("FAIL event: got valid=%0b err=%0b data=%h last=%0b done=%0b cyc=%0d, want err=%0b data=%h last=%0b cyc=%0d",
                        payload_valid, udp_err, payload_data, payload_last, udp_done, cyc,
                        e.is_err, e.data, e.last, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic drive(input logic [7:0] b, input logic hd);
      @(negedge aclk);
      data_in        = b;
      data_valid     = 1'b1;
      ip_header_done = hd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge aclk);
         data_valid     = 1'b0;
         ip_header_done = 1'b0;
         data_in        = 8'h00;
      end
   endtask

   task automatic push(input bit is_err, input logic [7:0] d, input bit last);
      ev_t e;
      e.is_err = is_err;
      e.data   = d;
      e.last   = last;
      e.cyc    = cyc + 1;   // registered output appears one cycle later
      exp_q.push_back(e);
   endtask

   task automatic header(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
      bit port_ok;
      bit len_ok;
      port_ok = (dst == 16'h04D2);
      len_ok  = (len >= 16'd9) && (len <= 16'd1480);
      drive(src[15:8], 1'b1);
      drive(src[7:0], 1'b0);
      drive(dst[15:8], 1'b0);
      drive(dst[7:0], 1'b0);
      drive(len[15:8], 1'b0);
      drive(len[7:0], 1'b0);
      if (port_ok && !len_ok) push(1'b1, 8'h00, 1'b0);
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b0);
   endtask

   // Full frame: header, n_pay payload bytes, n_pad zero bytes, then gap.
   task automatic frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                        input int n_pay, input int n_pad);
      bit         ok;
      int         plen;
      int         total;
      logic [7:0] b;
      ok    = (dst == 16'h04D2) && (len >= 16'd9) && (len <= 16'd1480);
      plen  = int'(len) - 8;
      total = n_pay + n_pad;
      header(src, dst, len);
      for (int i = 0; i < total; i++) begin
         b = (i < n_pay) ? 8'(8'hAA + 8'(i * 17)) : 8'h00;
         // A stray ip_header_done mid-frame must be ignored.
         drive(b, (i == 1) ? 1'b1 : 1'b0);
         if (ok && i < plen) push(1'b0, b, (i == plen - 1));
      end
      @(negedge aclk);
      data_valid     = 1'b0;
      ip_header_done = 1'b0;
      if (ok && total < plen) push(1'b1, 8'h00, 1'b0);
      idle(3);
   endtask

   initial begin
      int wait_cnt;
      // Reset state
      idle(2);
      chk("rst_s_port", udp_s_port, 16'h0000);
      chk("rst_len", udp_len, 16'h0000);
      chk("rst_data", {8'h00, payload_data}, 16'h0000);
      chk("rst_flags", {12'h000, payload_valid, payload_last, udp_done, udp_err}, 16'h0000);
      @(negedge aclk);
      areset = 1'b0;
      idle(2);

      // Good frame
      frame(16'h3039, 16'h04D2, 16'h000C, 4, 0);
      chk("good_s_port", udp_s_port, 16'h3039);
      chk("good_len", udp_len, 16'd12);

      // Port mismatch: nothing changes
      frame(16'h1111, 16'h04D3, 16'h000C, 4, 0);
      chk("mismatch_s_port", udp_s_port, 16'h3039);
      chk("mismatch_len", udp_len, 16'd12);

      // Bad lengths: too short, too long, just below minimum
      frame(16'h2222, 16'h04D2, 16'h0005, 2, 0);
      frame(16'h2222, 16'h04D2, 16'h05C9, 2, 0);
      frame(16'h2222, 16'h04D2, 16'h0008, 2, 0);
      chk("badlen_s_port", udp_s_port, 16'h3039);
      chk("badlen_len", udp_len, 16'd12);

      // Truncation: 3 of 8 bytes
      frame(16'h5555, 16'h04D2, 16'h0010, 3, 0);
      chk("trunc_s_port", udp_s_port, 16'h5555);
      chk("trunc_len", udp_len, 16'h0010);

      // Minimum length plus Ethernet padding
      frame(16'h6666, 16'h04D2, 16'h0009, 1, 20);
      chk("pad_len", udp_len, 16'h0009);

      // Maximum length
      frame(16'h7777, 16'h04D2, 16'h05C8, 1472, 4);
      chk("max_s_port", udp_s_port, 16'h7777);
      chk("max_len", udp_len, 16'h05C8);

      // Reset mid-payload
      header(16'h8888, 16'h04D2, 16'h0010);
      drive(8'h11, 1'b0);
      push(1'b0, 8'h11, 1'b0);
      drive(8'h22, 1'b0);
      push(1'b0, 8'h22, 1'b0);
      @(negedge aclk);
      areset = 1'b1;
      data_in = 8'h33;
      @(negedge aclk);
      chk("midrst_s_port", udp_s_port, 16'h0000);
      chk("midrst_len", udp_len, 16'h0000);
      chk("midrst_flags", {8'h00, payload_data}, 16'h0000);
      chk("midrst_strobes", {12'h000, payload_valid, payload_last, udp_done, udp_err}, 16'h0000);
      areset = 1'b0;
      data_valid = 1'b0;
      idle(3);

      // Recovery frame
      frame(16'h3039, 16'h04D2, 16'h000C, 4, 2);
      chk("recover_s_port", udp_s_port, 16'h3039);
      chk("recover_len", udp_len, 16'd12);

      // Bounded drain of any outstanding expectations
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(negedge aclk);
         wait_cnt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
